dog_layer_sched: RTL and testbench
==================================

# dog_layer_sched

Scheduler that shares one signed subtractor across the three Difference-of-Gaussian (DoG) layer pairs of the SIFT front end. It accepts one pixel position per handshake, carrying four co-located Gaussian blur levels (blur0 through blur3, from the 3x3, 5x5 and 7x7 chains). It issues three subtractions back-to-back and emits one tagged DoG sample per cycle. It also tracks raster position over a COLS x ROWS frame and sits between the blur line-buffer outputs and the keypoint extrema detector.

## Interface
Parameters:
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- PIX_W, 9, unsigned blur pixel width
- CW, $clog2(COLS) (10), column counter width
- RW, $clog2(ROWS) (9), row counter width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous and active-low
- start  in  1  one-cycle pulse arming a new frame
- busy  out  1  frame in progress
- in_valid  in  1  blur quad present
- in_ready  out  1  quad accepted on a clk edge where in_valid && in_ready
- in_blur0..in_blur3  in  PIX_W each  blur levels, increasing sigma
- out_valid  out  1  DoG sample valid this cycle
- out_layer  out  2  DoG layer index 0..2
- out_dog  out  PIX_W+1 signed  DoG value
- out_col  out  CW  column tag of out_dog
- out_row  out  RW  row tag of out_dog
- frame_done  out  1  one-cycle pulse on the final DoG sample of the frame

## Operation
- States: IDLE, SUB0, SUB1, SUB2.
  - The state register only moves when a capture occurs or the sequence advances.
- Each layer computes out_dog = {1'b0, in_blur(k+1)} - {1'b0, in_blur(k)} on captured values, for k = out_layer.
  - Arithmetic is PIX_W+1 bit two's complement and can never overflow; the range is -(2^PIX_W-1)..+(2^PIX_W-1).
- On capture, all four blurs and the current (col,row) are latched into holding registers.
- Input data is don't-care outside a capture edge.
- in_ready = busy && !all_captured && (state==IDLE || state==SUB2). It is combinational from registered state only.
- Capture transitions:
  - From IDLE, a capture moves to SUB0.
  - From SUB2, a capture moves to SUB0; otherwise SUB2 returns to IDLE.
- SUB0 always moves to SUB1, and SUB1 always moves to SUB2.
- Raster counter advances on each capture:
  - col increments; at col==COLS-1 it wraps to 0 and row increments.
  - After capture of (COLS-1, ROWS-1), all_captured is set and in_ready stays low for the rest of the frame.
- start:
  - When busy==0, start sets busy and clears col, row and all_captured.
  - When busy==1, start is ignored with no effect on counters or pipeline.
- Frame end:
  - busy clears on the edge that loads the layer-2 output of pixel (COLS-1, ROWS-1).
  - frame_done is registered on that same edge, so it is high in the same cycle as that out_valid.
- in_valid with busy==0 is ignored.

## Timing
- Reset (rst_n==0 at an edge): state=IDLE; busy, out_valid and frame_done = 0; out_layer, out_dog, out_col and out_row = 0; counters = 0; all_captured = 0.
- Reset mid-frame discards the in-flight pixel; no further out_valid follows.
- Capture at edge E0 produces out_valid on three consecutive cycles:
  - the cycle after E1, with layer 0;
  - the cycle after E2, with layer 1;
  - the cycle after E3, with layer 2.
- Latency is 2 edges from capture to the first DoG sample.
- Peak throughput is 1 pixel per 3 cycles with in_valid held high, giving continuous out_valid.
- Without in_valid during SUB2, the next pixel costs 4+ cycles, with an out_valid gap of at least 1 cycle.
- No output backpressure: the consumer must accept every out_valid cycle.
- out_col and out_row stay constant across the three layers of one pixel.

## Test plan
- Sign check: blur quad (5,6,6,5) → out_dog = +1, 0, -1 (10'h3FF) on layers 0, 1, 2, in consecutive cycles starting 2 edges after capture.
- Extremes with PIX_W=9: quad (0,511,0,511) → +511, -511, +511. Compare every value against an unsigned-extended subtraction model.
- Full-rate frame with COLS=4, ROWS=2 and in_valid tied high after start:
  - exactly 24 out_valid cycles with no gaps and col/row tags in raster order;
  - frame_done is high only with layer 2 of (3,1);
  - busy falls on that same edge and in_ready is never high after the 8th capture.
- Random in_valid (50%):
  - every captured quad yields exactly 3 outputs in order;
  - in_ready is never asserted in SUB0 or SUB1;
  - no output duplication or loss; scoreboard matches.
- start while busy mid-frame → ignored; the frame still completes at 24 outputs. start after frame_done → a new frame begins at (0,0).
- rst_n=0 asserted in SUB1 → the next cycle has all outputs 0 and state IDLE, and no further out_valid. in_valid with busy==0 → no capture.

Source files
------------

// File: rtl/dog_layer_sched.sv
// Shares one signed subtractor across the three DoG layer pairs.
// Each captured blur quad is issued as three back-to-back tagged DoG samples.
module dog_layer_sched #(
  parameter int unsigned COLS  = 640,
  parameter int unsigned ROWS  = 480,
  parameter int unsigned PIX_W = 9,
  parameter int unsigned CW    = $clog2(COLS),
  parameter int unsigned RW    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_blur0,
  input  logic [PIX_W-1:0] in_blur1,
  input  logic [PIX_W-1:0] in_blur2,
  input  logic [PIX_W-1:0] in_blur3,
  output logic             out_valid,
  output logic [1:0]       out_layer,
  output logic [PIX_W:0]   out_dog,
  output logic [CW-1:0]    out_col,
  output logic [RW-1:0]    out_row,
  output logic             frame_done
);

  typedef enum logic [1:0] {StIdle, StSub0, StSub1, StSub2} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             all_cap_q, all_cap_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic [CW-1:0]    hcol_q, hcol_d;
  logic [RW-1:0]    hrow_q, hrow_d;
  logic             hlast_q, hlast_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_layer_q, out_layer_d;
  logic [PIX_W:0]   out_dog_q, out_dog_d;
  logic [CW-1:0]    out_col_q, out_col_d;
  logic [RW-1:0]    out_row_q, out_row_d;
  logic             frame_done_q, frame_done_d;

  logic             capture, last_pix, frame_end, start_ok;
  logic [PIX_W-1:0] sub_a, sub_b;

  assign in_ready  = busy_q && !all_cap_q && (state_q == StIdle || state_q == StSub2);
  assign capture   = in_valid && in_ready;
  assign last_pix  = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));
  assign frame_end = (state_q == StSub2) && hlast_q;
  assign start_ok  = start && !busy_q;

  always_comb begin
    sub_a       = b3_q;
    sub_b       = b2_q;
    out_layer_d = 2'd2;
    case (state_q)
      StSub0: begin
        sub_a       = b1_q;
        sub_b       = b0_q;
        out_layer_d = 2'd0;
      end
      StSub1: begin
        sub_a       = b2_q;
        sub_b       = b1_q;
        out_layer_d = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    all_cap_d    = all_cap_q;
    col_d        = col_q;
    row_d        = row_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    b3_d         = b3_q;
    hcol_d       = hcol_q;
    hrow_d       = hrow_q;
    hlast_d      = hlast_q;
    out_valid_d  = (state_q != StIdle);
    out_dog_d    = out_dog_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    frame_done_d = frame_end;

    case (state_q)
      StIdle:  if (capture) state_d = StSub0;
      StSub0:  state_d = StSub1;
      StSub1:  state_d = StSub2;
      default: state_d = capture ? StSub0 : StIdle;
    endcase

    if (state_q != StIdle) begin
      out_dog_d = {1'b0, sub_a} - {1'b0, sub_b};
      out_col_d = hcol_q;
      out_row_d = hrow_q;
    end

    if (capture) begin
      b0_d    = in_blur0;
      b1_d    = in_blur1;
      b2_d    = in_blur2;
      b3_d    = in_blur3;
      hcol_d  = col_q;
      hrow_d  = row_q;
      hlast_d = last_pix;
      if (last_pix) all_cap_d = 1'b1;
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // A start while busy is ignored, so it can never collide with frame_end.
    if (start_ok) begin
      busy_d    = 1'b1;
      col_d     = '0;
      row_d     = '0;
      all_cap_d = 1'b0;
    end else if (frame_end) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      all_cap_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
      hcol_q       <= '0;
      hrow_q       <= '0;
      hlast_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_layer_q  <= '0;
      out_dog_q    <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      all_cap_q    <= all_cap_d;
      col_q        <= col_d;
      row_q        <= row_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      b3_q         <= b3_d;
      hcol_q       <= hcol_d;
      hrow_q       <= hrow_d;
      hlast_q      <= hlast_d;
      out_valid_q  <= out_valid_d;
      out_layer_q  <= out_valid_d ? out_layer_d : out_layer_q;
      out_dog_q    <= out_dog_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_layer  = out_layer_q;
  assign out_dog    = out_dog_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dog_layer_sched.sv
// Randomized bench for dog_layer_sched on a 4x2 frame against a behavioural
// model of per-pixel issue slots, plus hand-computed literal checks.
module tb_dog_layer_sched;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int PIX_W = 9;
  localparam int CW    = 2;
  localparam int RW    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_blur0 = '0, in_blur1 = '0, in_blur2 = '0, in_blur3 = '0;
  logic             out_valid;
  logic [1:0]       out_layer;
  logic [PIX_W:0]   out_dog;
  logic [CW-1:0]    out_col;
  logic [RW-1:0]    out_row;
  logic             frame_done;

  dog_layer_sched #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_blur0(in_blur0), .in_blur1(in_blur1), .in_blur2(in_blur2), .in_blur3(in_blur3),
    .out_valid(out_valid), .out_layer(out_layer), .out_dog(out_dog),
    .out_col(out_col), .out_row(out_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pixel owns three issue slots; the next one may enter once at most
  // one slot is left. Raster position is a linear pixel index.
  int       m_busy = 0, m_allcap = 0, m_idx = 0, m_left = 0;
  int       m_h[4];
  int       m_hidx = 0;
  bit       e_valid = 0, e_fd = 0;
  int       e_layer = 0, e_dog = 0, e_col = 0, e_row = 0;

  function automatic bit m_ready();
    return (m_busy != 0) && (m_allcap == 0) && (m_left <= 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_allcap = 0; m_idx = 0; m_left = 0; m_hidx = 0;
      e_valid = 0; e_fd = 0; e_layer = 0; e_dog = 0; e_col = 0; e_row = 0;
    end else begin
      bit cap, st;
      cap = m_ready() && in_valid;
      st  = start && (m_busy == 0);
      if (m_left > 0) begin
        int k;
        k       = 3 - m_left;
        e_valid = 1;
        e_layer = k;
        e_dog   = (m_h[k+1] - m_h[k]) & 32'h3FF;
        e_col   = m_hidx % COLS;
        e_row   = m_hidx / COLS;
        e_fd    = (m_left == 1) && (m_hidx == COLS * ROWS - 1);
        if (e_fd) m_busy = 0;
        m_left--;
      end else begin
        e_valid = 0;
        e_fd    = 0;
      end
      if (cap) begin
        m_h[0] = int'(in_blur0); m_h[1] = int'(in_blur1);
        m_h[2] = int'(in_blur2); m_h[3] = int'(in_blur3);
        m_hidx = m_idx;
        m_left = 3;
        m_idx++;
        if (m_idx == COLS * ROWS) m_allcap = 1;
      end
      if (st) begin
        m_busy = 1; m_idx = 0; m_allcap = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy != 0));
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      if (e_valid) begin
        chk("out_layer", 32'(out_layer), 32'(e_layer));
        chk("out_dog", 32'(out_dog), 32'(e_dog));
        chk("out_col", 32'(out_col), 32'(e_col));
        chk("out_row", 32'(out_row), 32'(e_row));
      end
    end
  end

  task automatic rand_blur();
    in_blur0 = PIX_W'($urandom); in_blur1 = PIX_W'($urandom);
    in_blur2 = PIX_W'($urandom); in_blur3 = PIX_W'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Issue one quad from IDLE and check the three literal DoG results.
  task automatic one_quad(input int q0, q1, q2, q3, input int d0, d1, d2, string nm);
    in_valid = 1'b1;
    in_blur0 = PIX_W'(q0); in_blur1 = PIX_W'(q1); in_blur2 = PIX_W'(q2); in_blur3 = PIX_W'(q3);
    @(negedge clk); in_valid = 1'b0;
    chk({nm, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk); chk({nm, "_l0"}, {out_valid, out_layer, out_dog}, {1'b1, 2'd0, 10'(d0)});
    @(negedge clk); chk({nm, "_l1"}, {out_valid, out_layer, out_dog}, {1'b1, 2'd1, 10'(d1)});
    @(negedge clk); chk({nm, "_l2"}, {out_valid, out_layer, out_dog}, {1'b1, 2'd2, 10'(d2)});
  endtask

  // Run one frame; returns number of outputs, span first..last, and first tag.
  task automatic run_frame(input bit full_rate, input bit mid_start,
                           output int cnt, output int span, output int first_tag);
    int first, last;
    bit done;
    cnt = 0; first = -1; last = -1; first_tag = -1; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (first < 0) begin
          first     = i;
          first_tag = {out_row, out_col};
        end
        last = i;
      end
      if (frame_done) begin
        done = 1;
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("done_tag", {out_layer, out_row, out_col}, {2'd2, 1'd1, 2'd3});
      end
      start    = mid_start && (i == 6);
      in_valid = full_rate ? 1'b1 : 1'($urandom);
      rand_blur();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    span = last - first + 1;
  endtask

  initial begin
    int cnt, span, tag;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs", {busy, in_ready, out_valid, frame_done, out_layer, out_dog,
                          out_col, out_row}, 32'd0);
    rst_n = 1'b1;

    // in_valid while idle must not capture
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_ready", 32'(in_ready), 32'd0);
    chk("idle_no_out", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    pulse_start();
    chk("start_ready", {busy, in_ready}, 2'b11);
    one_quad(5, 6, 6, 5, 1, 0, 10'h3FF, "sign");
    one_quad(0, 511, 0, 511, 511, 10'h201, 511, "ext");

    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Full-rate frame with a start pulse mid-frame that must be ignored
    pulse_start();
    run_frame(1'b1, 1'b1, cnt, span, tag);
    chk("full_count", 32'(cnt), 32'd24);
    chk("full_no_gap", 32'(span), 32'd24);
    chk("full_first_tag", 32'(tag), 32'd0);

    // Random-valid frames restarted after frame_done
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      run_frame(1'b0, 1'b1, cnt, span, tag);
      chk("rand_count", 32'(cnt), 32'd24);
      chk("rand_first_tag", 32'(tag), 32'd0);
    end

    // Reset asserted while in SUB1
    pulse_start();
    in_valid = 1'b1; rand_blur();
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", {busy, in_ready, out_valid, frame_done, out_layer, out_dog,
                              out_col, out_row}, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {out_valid, in_ready}, 2'b00);
    end
    in_valid = 1'b0;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
